// File: rtl/button_conditioner.sv
// Input front end for the parking meter: synchronizes and debounces four pushbuttons
// (one pulse per press) and two switches (clean levels) ahead of the incrementer.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic u,
  input  logic l,
  input  logic r,
  input  logic d,
  input  logic sw0,
  input  logic sw1,
  output logic u_pulse,
  output logic l_pulse,
  output logic r_pulse,
  output logic d_pulse,
  output logic sw0_db,
  output logic sw1_db
);

  localparam int NCH  = 6;
  localparam int NBTN = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [NCH-1:0] raw;
  logic [NCH-1:0] s1_q;
  logic [NCH-1:0] s2_q;
  logic [NCH-1:0] out_vec;

  // Channels 0..3 are buttons, 4..5 are switches.
  assign raw = {sw1, sw0, d, r, l, u};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             accept;
    logic             release_done;

    always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      accept       = 1'b0;
      release_done = 1'b0;
      case (state_q)
        IDLE: begin
          if (s2_q[i]) begin
            state_d = PRESS_WAIT;
            cnt_d   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!s2_q[i]) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = HELD;
            accept  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HELD: begin
          if (!s2_q[i]) begin
            state_d = RELEASE_WAIT;
            cnt_d   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (s2_q[i]) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d      = IDLE;
            release_done = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Buttons emit a single-cycle pulse on acceptance; switches hold a level.
    if (i < NBTN) begin : g_btn
      assign out_d = accept;
    end else begin : g_sw
      assign out_d = accept | (out_q & ~release_done);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        out_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        out_q   <= out_d;
      end
    end

    assign out_vec[i] = out_q;
  end

  assign u_pulse = out_vec[0];
  assign l_pulse = out_vec[1];
  assign r_pulse = out_vec[2];
  assign d_pulse = out_vec[3];
  assign sw0_db  = out_vec[4];
  assign sw1_db  = out_vec[5];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4: press latency, glitch
// rejection, release bounce, switch levels, channel independence and mid-debounce reset.
module tb_button_conditioner;

  logic clk, rst_n;
  logic u, l, r, d, sw0, sw1;
  logic u_pulse, l_pulse, r_pulse, d_pulse, sw0_db, sw1_db;

  int checks   = 0;
  int failures = 0;
  int cyc;
  int n_u, n_l, n_r, n_d;
  int first_u, first_l, first_r, first_d;
  int sw1_low_seen;

  button_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .u(u), .l(l), .r(r), .d(d), .sw0(sw0), .sw1(sw1),
    .u_pulse(u_pulse), .l_pulse(l_pulse), .r_pulse(r_pulse), .d_pulse(d_pulse),
    .sw0_db(sw0_db), .sw1_db(sw1_db)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample 1 time unit after the edge, and tally pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (u_pulse) begin n_u++; if (first_u < 0) first_u = cyc; end
    if (l_pulse) begin n_l++; if (first_l < 0) first_l = cyc; end
    if (r_pulse) begin n_r++; if (first_r < 0) first_r = cyc; end
    if (d_pulse) begin n_d++; if (first_d < 0) first_d = cyc; end
  endtask

  task automatic clr();
    cyc = 0;
    n_u = 0; n_l = 0; n_r = 0; n_d = 0;
    first_u = -1; first_l = -1; first_r = -1; first_d = -1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    // Reset held with every input high.
    rst_n = 1'b0;
    {u, l, r, d, sw0, sw1} = 6'b111111;
    clr();
    ticks(3);
    check("reset_outputs", {u_pulse, l_pulse, r_pulse, d_pulse, sw0_db, sw1_db}, 6'b0);
    check("reset_no_pulse", n_u + n_l + n_r + n_d, 0);

    // Release: first sample on tick 1, acceptance visible after tick 7.
    rst_n = 1'b1;
    clr();
    ticks(6);
    check("t1_sw_before", {sw1_db, sw0_db}, 2'b00);
    tick();
    check("t1_sw_rise", {sw1_db, sw0_db}, 2'b11);
    ticks(5);
    check("t1_sw_stay", {sw1_db, sw0_db}, 2'b11);
    check("t1_u_count", n_u, 1);
    check("t1_u_cycle", first_u, 7);
    check("t1_l_count", n_l, 1);
    check("t1_l_cycle", first_l, 7);
    check("t1_r_count", n_r, 1);
    check("t1_r_cycle", first_r, 7);
    check("t1_d_count", n_d, 1);
    check("t1_d_cycle", first_d, 7);

    // Everything released: switch fall has the same latency, no release pulses.
    {u, l, r, d, sw0, sw1} = 6'b000000;
    clr();
    ticks(6);
    check("t1_sw_fall_before", {sw1_db, sw0_db}, 2'b11);
    tick();
    check("t1_sw_fall", {sw1_db, sw0_db}, 2'b00);
    ticks(5);
    check("t1_release_pulses", n_u + n_l + n_r + n_d, 0);

    // Short u runs (3 and 2 cycles) are rejected.
    clr();
    u = 1'b1; ticks(3);
    u = 1'b0; ticks(10);
    u = 1'b1; ticks(2);
    u = 1'b0; ticks(15);
    check("t2_short_no_pulse", n_u, 0);
    clr();
    u = 1'b1; ticks(12);
    check("t2_idle_count", n_u, 1);
    check("t2_idle_cycle", first_u, 7);
    u = 1'b0; ticks(10);

    // r held 20 cycles with single-cycle dropouts on samples 9 and 13.
    clr();
    for (int k = 1; k <= 20; k++) begin
      r = (k == 9 || k == 13) ? 1'b0 : 1'b1;
      tick();
    end
    r = 1'b0;
    ticks(10);
    check("t3_r_count", n_r, 1);
    check("t3_r_cycle", first_r, 7);
    clr();
    r = 1'b1; ticks(10);
    check("t3_idle_cycle", first_r, 7);
    r = 1'b0; ticks(10);

    // l and d pressed together.
    clr();
    l = 1'b1; d = 1'b1;
    ticks(10);
    check("t4_l_count", n_l, 1);
    check("t4_d_count", n_d, 1);
    check("t4_l_cycle", first_l, 7);
    check("t4_d_cycle", first_d, 7);
    check("t4_u_r_quiet", n_u + n_r, 0);
    l = 1'b0; d = 1'b0;
    ticks(10);

    // sw1 rise, 3-cycle dip, then fall.
    clr();
    sw1 = 1'b1;
    ticks(6);
    check("t5_rise_before", sw1_db, 1'b0);
    tick();
    check("t5_rise", sw1_db, 1'b1);
    ticks(3);
    sw1_low_seen = 0;
    sw1 = 1'b0;
    for (int k = 0; k < 3; k++) begin tick(); if (!sw1_db) sw1_low_seen++; end
    sw1 = 1'b1;
    for (int k = 0; k < 10; k++) begin tick(); if (!sw1_db) sw1_low_seen++; end
    check("t5_dip_hold", sw1_low_seen, 0);
    sw1 = 1'b0;
    ticks(6);
    check("t5_fall_before", sw1_db, 1'b1);
    tick();
    check("t5_fall", sw1_db, 1'b0);
    check("t5_sw0_quiet", sw0_db, 1'b0);
    ticks(5);

    // Reset mid-debounce, u still held through release.
    clr();
    u = 1'b1;
    ticks(4);
    rst_n = 1'b0;
    ticks(2);
    check("t6_reset_no_pulse", n_u, 0);
    check("t6_reset_out", u_pulse, 1'b0);
    rst_n = 1'b1;
    clr();
    ticks(12);
    check("t6_after_count", n_u, 1);
    check("t6_after_cycle", first_u, 7);
    u = 1'b0;
    ticks(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end input stage for the parking meter; sits directly upstream of the incrementer.
- Takes raw, asynchronous pushbuttons (u, l, r, d) and the two reset switches (sw0, sw1) from the board.
- Per input: 2-FF synchronizer, then a counter-based debounce FSM.
- Buttons produce exactly one single-cycle pulse per physical press; switches produce clean debounced levels.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized cycles needed to accept an edge (10 ms at 100 MHz); must be >= 2.
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
clk  input  1  system clock, 100 MHz board clock.
rst_n  input  1  asynchronous active-low reset.
u  input  1  raw up button, active-high, asynchronous.
l  input  1  raw left button, active-high, asynchronous.
r  input  1  raw right button, active-high, asynchronous.
d  input  1  raw down button, active-high, asynchronous.
sw0  input  1  raw switch 0, asynchronous.
sw1  input  1  raw switch 1, asynchronous.
u_pulse  output  1  one-cycle pulse per accepted u press.
l_pulse  output  1  one-cycle pulse per accepted l press.
r_pulse  output  1  one-cycle pulse per accepted r press.
d_pulse  output  1  one-cycle pulse per accepted d press.
sw0_db  output  1  debounced level of sw0.
sw1_db  output  1  debounced level of sw1.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All synchronizer flops = 0.
  - All FSMs in IDLE; all counters = 0.
  - All outputs = 0.
  - Asserting reset mid-debounce abandons that debounce.
  - Release is synchronous to the next clk edge.
- Synchronizer: 2 flops per input (s1 <= raw, s2 <= s1). Only s2 feeds the FSM.
- Per-channel FSM, six identical instances. States:
  - IDLE: s2=1 -> PRESS_WAIT, cnt <= 0; else stay.
  - PRESS_WAIT: s2=0 -> IDLE, cnt <= 0. s2=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD. s2=1 otherwise -> cnt <= cnt+1.
  - HELD: s2=0 -> RELEASE_WAIT, cnt <= 0; else stay (no further pulses).
  - RELEASE_WAIT: s2=1 -> HELD, cnt <= 0. s2=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE. s2=0 otherwise -> cnt <= cnt+1.
- Button outputs:
  - x_pulse is registered; high for exactly the one cycle after the PRESS_WAIT->HELD edge.
  - Latency: raw first sampled high at edge E0 and held -> pulse high in the cycle after edge E0+2+DEBOUNCE_CYCLES.
  - A raw high run shorter than DEBOUNCE_CYCLES+1 cycles produces no pulse.
  - Bounce during release (RELEASE_WAIT back to HELD) never re-pulses.
  - A new pulse requires a full return to IDLE first.
- Switch outputs: swN_db is registered.
  - Set to 1 on the PRESS_WAIT->HELD transition.
  - Cleared to 0 on the RELEASE_WAIT->IDLE transition.
  - Same latency on both edges.
- Channel independence:
  - Channels are fully independent.
  - Simultaneous accepted presses pulse in the same cycle; no priority or arbitration (the incrementer sums them).
- Counter:
  - Saturates logically at DEBOUNCE_CYCLES-1, because the FSM leaves the wait state there.
  - No wrap-around is reachable.
- Button held through reset release: the channel starts in IDLE and emits one pulse after full debounce.

Test Plan (DEBOUNCE_CYCLES=4 unless stated):
1. Reset with all inputs high, then release at edge 0. -> All outputs 0 during reset. u_pulse, l_pulse, r_pulse, d_pulse each high exactly once, in the cycle after edge 6. sw0_db and sw1_db rise after edge 6 and stay 1.
2. u high for 3 cycles, low 10, high 2, low. -> u_pulse never asserts; FSM back in IDLE.
3. r held 20 cycles with 1-cycle low glitches at cycles 9 and 13, then released for 10 cycles. -> Exactly one r_pulse, after edge 6; no pulse after the glitches or on release. Channel ends in IDLE.
4. l and d rising on the same edge, held 10 cycles. -> l_pulse and d_pulse high in the same single cycle; u_pulse and r_pulse stay 0.
5. sw1 rises, held 10 cycles, then falls. -> sw1_db rises after edge 6 of the rise and falls after edge 6 of the fall. A 3-cycle low dip while high leaves sw1_db at 1.
6. DEBOUNCE_CYCLES=1000000; press u and rst_n low at 500000 cycles into the press. -> No pulse. After reset release with u still held, exactly one pulse 1000002 cycles later.
